// File: rtl/mem_port_arbiter_if.sv
// Request, completion and external-bus signals of the memory port arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              o_if_gnt;
    logic              o_if_valid;
    logic [DATA_W-1:0] o_if_rdata;

    logic              i_d_req;
    logic              i_d_we;
    logic [ADDR_W-1:0] i_d_addr;
    logic [DATA_W-1:0] i_d_wdata;
    logic [BE_W-1:0]   i_d_be;
    logic              o_d_gnt;
    logic              o_d_valid;
    logic [DATA_W-1:0] o_d_rdata;

    logic              o_bus_req;
    logic              o_bus_we;
    logic [ADDR_W-1:0] o_bus_addr;
    logic [DATA_W-1:0] o_bus_wdata;
    logic [BE_W-1:0]   o_bus_be;
    logic              i_bus_ack;
    logic [DATA_W-1:0] i_bus_rdata;

    logic              o_busy;
    logic              o_timeout;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_valid, o_if_rdata,
        input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
        output o_d_gnt, o_d_valid, o_d_rdata,
        output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
        input  i_bus_ack, i_bus_rdata,
        output o_busy, o_timeout
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_valid, o_if_rdata,
        output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
        input  o_d_gnt, o_d_valid, o_d_rdata,
        input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
        output i_bus_ack, i_bus_rdata,
        input  o_busy, o_timeout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between fetch and data, data first,
// with a fetch starvation guard. Build option: MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 255
) (
    input logic i_clk,
    input logic i_reset_n,
    mem_port_arbiter_if.slave p
);
    localparam int BE_W = DATA_W / 8;
    localparam int SW   = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUS_IF,
        BUS_D
    } state_t;

    state_t state, state_nxt;

    logic [SW-1:0]     starve_cnt;
    logic              if_win, d_win, done, aborted;
    logic              if_gnt, d_gnt, if_valid, d_valid;
    logic [DATA_W-1:0] if_rdata, d_rdata;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [BE_W-1:0]   bus_be;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_flag;

    assign aborted = (state != IDLE) && !p.i_bus_ack
                     && (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else if (aborted) begin
            tmo_flag <= 1'b1;
        end else if (!p.i_bus_ack) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign p.o_timeout = tmo_flag;
`else
    assign aborted     = 1'b0;
    assign p.o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if_win    = 1'b0;
        d_win     = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                // A fetch that has lost MAX_WAIT times in a row beats data
                if_win = p.i_if_req &&
                         (!p.i_d_req || starve_cnt == SW'(MAX_WAIT));
                d_win  = p.i_d_req && !if_win;
                if (if_win)     state_nxt = BUS_IF;
                else if (d_win) state_nxt = BUS_D;
            end
            BUS_IF, BUS_D: begin
                done = p.i_bus_ack || aborted;
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            starve_cnt <= '0;
            if_gnt     <= 1'b0;
            d_gnt      <= 1'b0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
        end else begin
            if_gnt   <= if_win;
            d_gnt    <= d_win;
            if_valid <= done && (state == BUS_IF);
            d_valid  <= done && (state == BUS_D);
            if (if_win) begin
                bus_we     <= 1'b0;
                bus_addr   <= p.i_if_addr;
                bus_wdata  <= '0;
                bus_be     <= '1;
                starve_cnt <= '0;
            end else if (d_win) begin
                bus_we    <= p.i_d_we;
                bus_addr  <= p.i_d_addr;
                bus_wdata <= p.i_d_wdata;
                bus_be    <= p.i_d_we ? p.i_d_be : '1;
                if (p.i_if_req && starve_cnt != SW'(MAX_WAIT))
                    starve_cnt <= starve_cnt + 1'b1;
            end
            if (done && state == BUS_IF)
                if_rdata <= aborted ? '0 : p.i_bus_rdata;
            if (done && state == BUS_D)
                d_rdata <= (aborted || bus_we) ? '0 : p.i_bus_rdata;
        end
    end

    assign p.o_if_gnt    = if_gnt;
    assign p.o_if_valid  = if_valid;
    assign p.o_if_rdata  = if_rdata;
    assign p.o_d_gnt     = d_gnt;
    assign p.o_d_valid   = d_valid;
    assign p.o_d_rdata   = d_rdata;
    assign p.o_bus_req   = (state != IDLE);
    assign p.o_bus_we    = bus_we;
    assign p.o_bus_addr  = bus_addr;
    assign p.o_bus_wdata = bus_wdata;
    assign p.o_bus_be    = bus_be;
    assign p.o_busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus
// directed scenarios with literal expectations.
module tb_mem_port_arbiter;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;
    localparam int TIMEOUT  = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .p(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: who owns the bus, how often fetch lost, what was latched
    int          owner;
    int          losses;
    int          elapsed;
    bit          m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    bit          e_if_gnt, e_d_gnt, e_if_valid, e_d_valid, e_tmo;
    logic [31:0] e_if_rdata, e_d_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner = 0; losses = 0; elapsed = 0;
            m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
            e_if_gnt = 0; e_d_gnt = 0; e_if_valid = 0; e_d_valid = 0;
            e_tmo = 0; e_if_rdata = 0; e_d_rdata = 0;
        end else begin
            e_if_gnt = 0; e_d_gnt = 0; e_if_valid = 0; e_d_valid = 0;
            if (owner == 0) begin
                if (bus.i_if_req && (!bus.i_d_req || losses == MAX_WAIT)) begin
                    owner = 1; losses = 0; elapsed = 0; e_if_gnt = 1;
                    m_we = 0; m_addr = bus.i_if_addr; m_be = 4'hF;
                end else if (bus.i_d_req) begin
                    owner = 2; elapsed = 0; e_d_gnt = 1;
                    if (bus.i_if_req && losses < MAX_WAIT) losses++;
                    m_we = bus.i_d_we; m_addr = bus.i_d_addr;
                    m_wdata = bus.i_d_wdata;
                    m_be = bus.i_d_we ? bus.i_d_be : 4'hF;
                end
            end else if (bus.i_bus_ack) begin
                if (owner == 1) begin
                    e_if_valid = 1; e_if_rdata = bus.i_bus_rdata;
                end else begin
                    e_d_valid = 1; e_d_rdata = m_we ? 32'h0 : bus.i_bus_rdata;
                end
                owner = 0;
            end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                elapsed++;
                if (elapsed == TIMEOUT) begin
                    e_tmo = 1;
                    if (owner == 1) begin e_if_valid = 1; e_if_rdata = 0; end
                    else begin e_d_valid = 1; e_d_rdata = 0; end
                    owner = 0;
                end
`endif
            end
        end
    end

    byte glog[$];
    int  n_if_valid = 0;
    int  n_d_valid  = 0;

    always @(posedge clk) begin
        #1;
        chk("if_gnt", bus.o_if_gnt, e_if_gnt);
        chk("d_gnt", bus.o_d_gnt, e_d_gnt);
        chk("if_valid", bus.o_if_valid, e_if_valid);
        chk("d_valid", bus.o_d_valid, e_d_valid);
        chk("bus_req", bus.o_bus_req, owner != 0);
        chk("busy", bus.o_busy, owner != 0);
        chk("timeout", bus.o_timeout, e_tmo);
        if (owner != 0) begin
            chk("bus_addr", bus.o_bus_addr, m_addr);
            chk("bus_we", bus.o_bus_we, m_we);
            chk("bus_be", bus.o_bus_be, m_be);
            if (m_we) chk("bus_wdata", bus.o_bus_wdata, m_wdata);
        end
        if (e_if_valid) chk("if_rdata", bus.o_if_rdata, e_if_rdata);
        if (e_d_valid) chk("d_rdata", bus.o_d_rdata, e_d_rdata);
        if (bus.o_if_gnt) glog.push_back("I");
        if (bus.o_d_gnt) glog.push_back("D");
        if (bus.o_if_valid) n_if_valid++;
        if (bus.o_d_valid) n_d_valid++;
    end

    // which: 0 if_gnt, 1 d_gnt, 2 if_valid, 3 d_valid
    task automatic wait_for(input int which, input int limit,
                            input string name, output int cycles);
        bit hit;
        hit = 0;
        cycles = 0;
        while (!hit && cycles < limit) begin
            @(negedge clk);
            cycles++;
            hit = (which == 0 && bus.o_if_gnt) || (which == 1 && bus.o_d_gnt)
               || (which == 2 && bus.o_if_valid) || (which == 3 && bus.o_d_valid);
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: no event within %0d cycles", name, limit);
        end
    endtask

    initial begin
        int  c, v_d, v_if;
        byte exp_order[10];
        exp_order = '{"D", "D", "D", "D", "I", "D", "D", "D", "D", "I"};
        bus.i_if_req = 0; bus.i_if_addr = 0;
        bus.i_d_req = 0; bus.i_d_we = 0; bus.i_d_addr = 0;
        bus.i_d_wdata = 0; bus.i_d_be = 0;
        bus.i_bus_ack = 0; bus.i_bus_rdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_bus_req", bus.o_bus_req, 0);
        chk("rst_bus_addr", bus.o_bus_addr, 0);
        rst_n = 1;
        @(negedge clk);

        // 1: fetch only, ack two cycles after bus_req
        bus.i_if_req = 1; bus.i_if_addr = 32'h10;
        wait_for(0, 20, "t1_gnt", c);
        bus.i_if_req = 0;
        chk("t1_gnt_lat", c, 1);
        chk("t1_bus_addr", bus.o_bus_addr, 32'h10);
        chk("t1_bus_be", bus.o_bus_be, 4'hF);
        @(negedge clk);
        @(negedge clk);
        bus.i_bus_ack = 1; bus.i_bus_rdata = 32'h0050_0093;
        wait_for(2, 20, "t1_valid", c);
        bus.i_bus_ack = 0;
        chk("t1_valid_lat", c, 1);
        chk("t1_rdata", bus.o_if_rdata, 32'h0050_0093);
        chk("t1_no_dvalid", n_d_valid, 0);

        // 2: store with immediate ack
        @(negedge clk);
        bus.i_d_req = 1; bus.i_d_we = 1; bus.i_d_addr = 32'h100;
        bus.i_d_wdata = 32'hCAFE_F00D; bus.i_d_be = 4'b0011;
        bus.i_bus_ack = 1; bus.i_bus_rdata = 32'hDEAD_BEEF;
        wait_for(1, 20, "t2_gnt", c);
        bus.i_d_req = 0;
        chk("t2_bus_we", bus.o_bus_we, 1);
        chk("t2_bus_addr", bus.o_bus_addr, 32'h100);
        chk("t2_bus_wdata", bus.o_bus_wdata, 32'hCAFE_F00D);
        chk("t2_bus_be", bus.o_bus_be, 4'b0011);
        @(negedge clk);
        bus.i_bus_ack = 0;
        chk("t2_valid_lat", bus.o_d_valid, 1);
        chk("t2_rdata", bus.o_d_rdata, 0);

        // 3: both requesters held high, continuous ack
        @(negedge clk);
        glog.delete();
        bus.i_d_req = 1; bus.i_d_we = 0; bus.i_d_addr = 32'h200;
        bus.i_if_req = 1; bus.i_if_addr = 32'h40;
        bus.i_bus_ack = 1; bus.i_bus_rdata = 32'h11;
        repeat (24) @(negedge clk);
        bus.i_d_req = 0; bus.i_if_req = 0;
        @(negedge clk);
        bus.i_bus_ack = 0;
        chk("t3_grants", glog.size() >= 10, 1);
        for (int i = 0; i < 10 && i < glog.size(); i++)
            chk($sformatf("t3_order%0d", i), glog[i], exp_order[i]);

        // 4: reset while a store waits for ack
        @(negedge clk);
        bus.i_d_req = 1; bus.i_d_we = 1; bus.i_d_addr = 32'h300;
        bus.i_d_wdata = 32'h1234; bus.i_d_be = 4'hF;
        wait_for(1, 20, "t4_gnt", c);
        bus.i_d_req = 0;
        @(negedge clk);
        v_d = n_d_valid;
        rst_n = 0;
        #1;
        chk("t4_rst_busy", bus.o_busy, 0);
        chk("t4_rst_bus_req", bus.o_bus_req, 0);
        chk("t4_rst_bus_addr", bus.o_bus_addr, 0);
        chk("t4_rst_bus_we", bus.o_bus_we, 0);
        chk("t4_rst_d_rdata", bus.o_d_rdata, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        bus.i_bus_ack = 1; bus.i_bus_rdata = 32'h55;
        @(negedge clk);
        bus.i_bus_ack = 0;
        repeat (3) @(negedge clk);
        chk("t4_no_dvalid", n_d_valid, v_d);
        chk("t4_idle", bus.o_busy, 0);

        // 5: ack with no owner
        v_d = n_d_valid; v_if = n_if_valid;
        bus.i_bus_ack = 1;
        repeat (4) @(negedge clk);
        bus.i_bus_ack = 0;
        chk("t5_busy", bus.o_busy, 0);
        chk("t5_no_valid", n_d_valid + n_if_valid, v_d + v_if);

`ifdef MEM_ARB_TIMEOUT_EN
        // 6: fetch never acknowledged
        @(negedge clk);
        bus.i_if_req = 1; bus.i_if_addr = 32'h80;
        wait_for(0, 20, "t6_gnt", c);
        bus.i_if_req = 0;
        wait_for(2, 300, "t6_valid", c);
        chk("t6_lat", c, 255);
        chk("t6_rdata", bus.o_if_rdata, 0);
        chk("t6_tmo", bus.o_timeout, 1);
        chk("t6_bus_req", bus.o_bus_req, 0);
        repeat (5) @(negedge clk);
        chk("t6_tmo_sticky", bus.o_timeout, 1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("t6_tmo_clr", bus.o_timeout, 0);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
